// File: rtl/kernel_pipe_pkg.sv
// Shared definitions for the two-stage vector kernel pipeline.
package kernel_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_AND = 2'b10,
        MODE_XOR = 2'b11
    } mode_e;

endpackage

// File: rtl/kernel_pipe_slot.sv
// Two-entry elastic slot: registered main entry plus skid entry, ready driven from a flop.
module kernel_pipe_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_r, main_valid_s;
    logic         skid_valid_r, skid_valid_s;
    logic [W-1:0] main_data_r,  main_data_s;
    logic [W-1:0] skid_data_r,  skid_data_s;
    logic         ready_r;
    logic         in_fire_s;
    logic         out_fire_s;

    // Next-state selection for the main and skid entries.
    always_comb begin
        in_fire_s    = in_valid & ready_r;
        out_fire_s   = main_valid_r & out_ready;
        main_valid_s = main_valid_r;
        main_data_s  = main_data_r;
        skid_valid_s = skid_valid_r;
        skid_data_s  = skid_data_r;
        if (out_fire_s || !main_valid_r) begin
            // Main entry is free this cycle: the older skid vector goes first.
            if (skid_valid_r) begin
                main_valid_s = 1'b1;
                main_data_s  = skid_data_r;
                skid_valid_s = 1'b0;
            end else if (in_fire_s) begin
                main_valid_s = 1'b1;
                main_data_s  = in_data;
            end else begin
                main_valid_s = 1'b0;
            end
        end else begin
            if (in_fire_s) begin
                skid_valid_s = 1'b1;
                skid_data_s  = in_data;
            end else begin
                skid_valid_s = skid_valid_r;
            end
        end
    end

    // Slot state registers; ready is the registered inverse of skid occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            main_data_r  <= '0;
            skid_data_r  <= '0;
            ready_r      <= 1'b0;
        end else begin
            main_valid_r <= main_valid_s;
            skid_valid_r <= skid_valid_s;
            main_data_r  <= main_data_s;
            skid_data_r  <= skid_data_s;
            ready_r      <= ~skid_valid_s;
        end
    end

    assign in_ready  = ready_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;

endmodule

// File: rtl/kernel_pipe_vect.sv
// Vector kernel: stage 1 applies a per-lane ALU op, stage 2 squares each lane.
module kernel_pipe_vect
    import kernel_pipe_pkg::*;
#(
    parameter int STREAMW = 32,
    parameter int NLANES  = 8,
    parameter int CNTW    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ivalid,
    output logic                        iready,
    input  logic [1:0]                  mode,
    input  logic [NLANES*STREAMW-1:0]   vin0,
    input  logic [NLANES*STREAMW-1:0]   vin1,
    output logic                        ovalid,
    input  logic                        oready,
    output logic [NLANES*STREAMW-1:0]   vout,
    output logic [CNTW-1:0]             ocount
);

    localparam int VW = NLANES * STREAMW;

    logic [VW-1:0]   local_s;
    logic [VW-1:0]   s1_data_s;
    logic [VW-1:0]   sq_s;
    logic            s1_valid_s;
    logic            s2_ready_s;
    logic [CNTW-1:0] count_r;

    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        logic [STREAMW-1:0] a_s, b_s, op_s, l_s;

        assign a_s = vin0[k*STREAMW +: STREAMW];
        assign b_s = vin1[k*STREAMW +: STREAMW];
        assign l_s = s1_data_s[k*STREAMW +: STREAMW];

        // Stage-1 lane operation, applied with the mode sampled alongside the vector.
        always_comb begin
            op_s = '0;
            case (mode)
                MODE_ADD: op_s = a_s + b_s;
                MODE_SUB: op_s = a_s - b_s;
                MODE_AND: op_s = a_s & b_s;
                MODE_XOR: op_s = a_s ^ b_s;
                default:  op_s = '0;
            endcase
        end

        assign local_s[k*STREAMW +: STREAMW] = op_s;
        assign sq_s[k*STREAMW +: STREAMW]    = l_s * l_s;
    end

    kernel_pipe_slot #(.W(VW)) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ivalid),
        .in_ready  (iready),
        .in_data   (local_s),
        .out_valid (s1_valid_s),
        .out_ready (s2_ready_s),
        .out_data  (s1_data_s)
    );

    kernel_pipe_slot #(.W(VW)) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid_s),
        .in_ready  (s2_ready_s),
        .in_data   (sq_s),
        .out_valid (ovalid),
        .out_ready (oready),
        .out_data  (vout)
    );

    // Output handshake counter, wrapping naturally at 2^CNTW.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (ovalid && oready) begin
            count_r <= count_r + CNTW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign ocount = count_r;

endmodule

// File: tb/tb_kernel_pipe_vect.sv
// Scoreboard bench: stimulus pushes hand-computed results, a monitor pops on each output transfer.
module tb_kernel_pipe_vect;
    import kernel_pipe_pkg::*;

    localparam int STREAMW = 32;
    localparam int NLANES  = 8;
    localparam int CNTW    = 4;
    localparam int VW      = NLANES * STREAMW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ivalid = 1'b0;
    logic            iready;
    logic [1:0]      mode = 2'b00;
    logic [VW-1:0]   vin0 = '0;
    logic [VW-1:0]   vin1 = '0;
    logic            ovalid;
    logic            oready = 1'b1;
    logic [VW-1:0]   vout;
    logic [CNTW-1:0] ocount;

    int            checks = 0;
    int            errors = 0;
    int            pushes = 0;
    int            pops = 0;
    int            exp_cnt = 0;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] exp_v;

    kernel_pipe_vect #(.STREAMW(STREAMW), .NLANES(NLANES), .CNTW(CNTW)) dut (
        .clk    (clk),
        .rst    (rst),
        .ivalid (ivalid),
        .iready (iready),
        .mode   (mode),
        .vin0   (vin0),
        .vin1   (vin1),
        .ovalid (ovalid),
        .oready (oready),
        .vout   (vout),
        .ocount (ocount)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] splat(input logic [STREAMW-1:0] x);
        logic [VW-1:0] v;
        for (int k = 0; k < NLANES; k++) v[k*STREAMW +: STREAMW] = x;
        return v;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present one vector at a negedge, wait (bounded) for acceptance, record its expected result.
    task automatic send(input logic [1:0] m, input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input logic [VW-1:0] e);
        int t = 0;
        mode = m; vin0 = a; vin1 = b; ivalid = 1'b1;
        while (!iready && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!iready) begin
            errors++;
            $display("FAIL send_timeout actual=%0d required=accept", t);
        end else begin
            exp_q.push_back(e);
            pushes++;
        end
        @(negedge clk);
        ivalid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; ivalid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: each output transfer is checked against the oldest expected vector.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                exp_cnt = 0;
            end else if (ovalid && oready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%h required=none", vout);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("vout", vout, exp_v);
                    chk("ocount_run", VW'(ocount), VW'(exp_cnt % 16));
                end
                exp_cnt++;
                pops++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] a, e;
        time t0;
        int idx;

        // Reset with ivalid held high
        ivalid = 1'b1; vin0 = splat(32'd3); vin1 = splat(32'd4);
        repeat (2) @(negedge clk);
        chk("rst_ovalid", VW'(ovalid), VW'(1'b0));
        chk("rst_iready", VW'(iready), VW'(1'b0));
        chk("rst_vout",   vout,        '0);
        chk("rst_ocount", VW'(ocount), VW'(4'd0));
        ivalid = 1'b0;
        rst = 1'b1;
        #1 chk("rel_iready_pre", VW'(iready), VW'(1'b0));
        @(posedge clk); #1;
        chk("rel_iready_post", VW'(iready), VW'(1'b1));
        @(negedge clk);

        // Add with latency check
        oready = 1'b1;
        mode = MODE_ADD; vin0 = splat(32'd3); vin1 = splat(32'd4); ivalid = 1'b1;
        exp_q.push_back(splat(32'd49)); pushes++;
        @(posedge clk); #1;
        ivalid = 1'b0;
        chk("lat_cycle1", VW'(ovalid), VW'(1'b0));
        @(posedge clk); #1;
        chk("lat_cycle2", VW'(ovalid), VW'(1'b1));
        chk("lat_vout", vout, splat(32'd49));
        drain();
        chk("add_ocount", VW'(ocount), VW'(4'd1));

        // Back-to-back vectors with mode changes, one per cycle
        @(negedge clk);
        t0 = $time;
        send(MODE_ADD, splat(32'h0001_0000), splat(32'd0), splat(32'd0));
        send(MODE_SUB, splat(32'd0), splat(32'd1), splat(32'd1));
        send(MODE_XOR, splat(32'd5), splat(32'd3), splat(32'd36));
        send(MODE_AND, splat(32'hF0F0_00FF), splat(32'h0000_0013), splat(32'd361));
        chk("throughput_time", VW'($time - t0), VW'(40));
        drain();
        chk("mix_ocount", VW'(ocount), VW'(4'd5));

        // Backpressure: oready low for cycles 3..9
        apply_reset();
        idx = 0;
        pushes = 0; pops = 0;
        for (int c = 0; c < 60 && idx < 10; c++) begin
            oready = !(c >= 3 && c <= 9);
            if (c == 8) begin
                chk("bp_inflight", VW'(pushes - pops), VW'(4));
                chk("bp_iready", VW'(iready), VW'(1'b0));
            end
            for (int k = 0; k < NLANES; k++) begin
                a[k*STREAMW +: STREAMW] = STREAMW'(k + idx);
                e[k*STREAMW +: STREAMW] = STREAMW'((k + idx) * (k + idx));
            end
            mode = MODE_AND; vin0 = a; vin1 = '1; ivalid = 1'b1;
            if (iready) begin
                exp_q.push_back(e);
                pushes++;
                idx++;
            end
            @(negedge clk);
        end
        ivalid = 1'b0;
        oready = 1'b1;
        drain();
        chk("bp_count", VW'(pops), VW'(10));
        chk("bp_ocount", VW'(ocount), VW'(4'd10));

        // Reset mid-stream with 3 vectors in flight
        apply_reset();
        oready = 1'b0;
        for (int i = 0; i < 3; i++) send(MODE_ADD, splat(32'd3), splat(32'd4), splat(32'd49));
        rst = 1'b0;
        exp_q.delete();
        #1 chk("mid_rst_ovalid", VW'(ovalid), VW'(1'b0));
        @(negedge clk);
        rst = 1'b1;
        oready = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_post_ovalid", VW'(ovalid), VW'(1'b0));
        send(MODE_XOR, splat(32'd5), splat(32'd3), splat(32'd36));
        drain();
        chk("mid_ocount", VW'(ocount), VW'(4'd1));

        // Counter wrap at CNTW=4
        apply_reset();
        oready = 1'b1;
        for (int i = 0; i < 17; i++) send(MODE_XOR, splat(32'd5), splat(32'd3), splat(32'd36));
        drain();
        chk("wrap_ocount", VW'(ocount), VW'(4'd1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
